// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, register-file write and hazard signals
// master: writeback requesters and decode; slave: the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             req0_valid;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             grant_id;
    logic [AW-1:0]    rd_addr;
    logic             rd_hazard;

    modport master (
        output req0_valid, req0_addr, req0_data, input req0_ready,
        output req1_valid, req1_addr, req1_data, input req1_ready,
        input  wr_en, wr_addr, wr_data, grant_id,
        output rd_addr, input rd_hazard
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, output req0_ready,
        input  req1_valid, req1_addr, req1_data, output req1_ready,
        output wr_en, wr_addr, wr_data, grant_id,
        input  rd_addr, output rd_hazard
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates ALU and load writebacks onto the register-file write port
// REGFILE_WB_FIXED_PRIO_EN: load (req1) always wins a tie instead of round-robin.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    logic             full0, full1;
    logic [AW-1:0]    buf0_addr, buf1_addr;
    logic [WIDTH-1:0] buf0_data, buf1_data;
    logic             grant0, grant1;
    logic             acc0, acc1;
    logic             wr_en_q;
    logic [AW-1:0]    wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic             grant_id_q;
`ifndef REGFILE_WB_FIXED_PRIO_EN
    logic             last_grant;
`endif

    // Grant depends only on buffer state, so ready never loops back through valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && full1) begin
`ifdef REGFILE_WB_FIXED_PRIO_EN
            grant1 = 1'b1;
`else
            grant0 = last_grant;
            grant1 = !last_grant;
`endif
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    assign bus.req0_ready = !rst && (!full0 || grant0);
    assign bus.req1_ready = !rst && (!full1 || grant1);
    assign acc0 = bus.req0_valid && bus.req0_ready;
    assign acc1 = bus.req1_valid && bus.req1_ready;

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.grant_id = grant_id_q;

    assign bus.rd_hazard = !rst && (bus.rd_addr != '0) &&
                           ((full0 && buf0_addr == bus.rd_addr) ||
                            (full1 && buf1_addr == bus.rd_addr) ||
                            (wr_en_q && wr_addr_q == bus.rd_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full0      <= 1'b0;
            full1      <= 1'b0;
            buf0_addr  <= '0;
            buf1_addr  <= '0;
            buf0_data  <= '0;
            buf1_data  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= 1'b0;
`ifndef REGFILE_WB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            if (grant0 || grant1) begin
                wr_en_q    <= 1'b1;
                wr_addr_q  <= grant1 ? buf1_addr : buf0_addr;
                wr_data_q  <= grant1 ? buf1_data : buf0_data;
                grant_id_q <= grant1;
`ifndef REGFILE_WB_FIXED_PRIO_EN
                last_grant <= grant1;
`endif
            end else begin
                wr_en_q <= 1'b0;
            end

            // Writes to x0 are acknowledged but never buffered.
            if (acc0 && bus.req0_addr != '0) begin
                full0     <= 1'b1;
                buf0_addr <= bus.req0_addr;
                buf0_data <= bus.req0_data;
            end else if (grant0) begin
                full0 <= 1'b0;
            end

            if (acc1 && bus.req1_addr != '0) begin
                full1     <= 1'b1;
                buf1_addr <= bus.req1_addr;
                buf1_data <= bus.req1_data;
            end else if (grant1) begin
                full1 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
`ifdef REGFILE_WB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    regfile_wb_arbiter_if #(.WIDTH(32), .AW(5)) bus ();
    regfile_wb_arbiter #(.WIDTH(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic v0; logic [4:0] a0; logic [31:0] d0;
        logic v1; logic [4:0] a1; logic [31:0] d1;
        logic [4:0] rd;
        logic r0; logic r1; logic wen; logic [4:0] wa; logic [31:0] wd; logic gid; logic hz;
    } vec_t;

    // Reference model: two pending slots, a tie-break memory and the visible write port.
    bit          m_full[2];
    logic [4:0]  m_addr[2];
    logic [31:0] m_data[2];
    bit          m_last;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_gid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic m_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_addr[0] = 0; m_addr[1] = 0;
        m_data[0] = 0; m_data[1] = 0;
        m_last = 1; m_wen = 0; m_waddr = 0; m_wdata = 0; m_gid = 0;
    endtask

    function automatic int m_winner();
        if (m_full[0] && m_full[1]) return FIXED ? 1 : (m_last ? 0 : 1);
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    task automatic m_step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        int w;
        bit take0, take1;
        w = m_winner();
        take0 = v0 && (!m_full[0] || w == 0);
        take1 = v1 && (!m_full[1] || w == 1);
        if (w >= 0) begin
            m_wen = 1; m_waddr = m_addr[w]; m_wdata = m_data[w];
            m_gid = (w == 1); m_last = (w == 1); m_full[w] = 0;
        end else begin
            m_wen = 0;
        end
        if (take0 && a0 != 0) begin m_full[0] = 1; m_addr[0] = a0; m_data[0] = d0; end
        if (take1 && a1 != 0) begin m_full[1] = 1; m_addr[1] = a1; m_data[1] = d1; end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] rd);
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.rd_addr = rd;
        #1;
    endtask

    task automatic idle(input logic [4:0] rd);
        drive(0, 0, 0, 0, 0, 0, rd);
    endtask

    task automatic rand_cycle(input int k);
        logic v0, v1;
        logic [4:0] a0, a1, rd;
        logic [31:0] d0, d1;
        int w;
        bit ehz;
        v0 = 1'($urandom_range(0, 1)); a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
        v1 = 1'($urandom_range(0, 1)); a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
        rd = 5'($urandom_range(0, 7));
        drive(v0, a0, d0, v1, a1, d1, rd);
        w = m_winner();
        ehz = (rd != 0) && ((m_full[0] && m_addr[0] == rd) || (m_full[1] && m_addr[1] == rd) ||
                            (m_wen && m_waddr == rd));
        chk($sformatf("rnd%0d_ready0", k), bus.req0_ready, !m_full[0] || w == 0);
        chk($sformatf("rnd%0d_ready1", k), bus.req1_ready, !m_full[1] || w == 1);
        chk($sformatf("rnd%0d_wr_en", k), bus.wr_en, m_wen);
        chk($sformatf("rnd%0d_wr_addr", k), bus.wr_addr, m_waddr);
        chk($sformatf("rnd%0d_wr_data", k), bus.wr_data, m_wdata);
        chk($sformatf("rnd%0d_grant_id", k), bus.grant_id, m_gid);
        chk($sformatf("rnd%0d_hazard", k), bus.rd_hazard, ehz);
        @(posedge clk);
        m_step(v0, a0, d0, v1, a1, d1);
    endtask

    initial begin
        vec_t vecs[11];
        int acc_n[2], wr_n[2];
        logic [4:0]  fa, sa;
        logic [31:0] fd, sd;

        bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
        bus.rd_addr = 0;
        m_reset();

        vecs[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 3,  1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 3,             1, 1, 0, 0, 0, 0, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 3,             1, 1, 1, 3, 32'hDEADBEEF, 0, 1};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 3,             1, 1, 0, 3, 32'hDEADBEEF, 0, 0};
        vecs[4]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,  1, 1, 0, 3, 32'hDEADBEEF, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 3, 32'hDEADBEEF, 0, 0};
        vecs[6]  = '{0, 0, 0, 1, 7, 32'h77, 7,        1, 1, 0, 3, 32'hDEADBEEF, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 7,             1, 1, 0, 3, 32'hDEADBEEF, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 7,             1, 1, 1, 7, 32'h77, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 7,             1, 1, 0, 7, 32'h77, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 8,             1, 1, 0, 7, 32'h77, 1, 0};

        #2;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        @(negedge clk);
        rst = 0;

        foreach (vecs[i]) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].rd);
            chk($sformatf("vec%0d_ready0", i), bus.req0_ready, vecs[i].r0);
            chk($sformatf("vec%0d_ready1", i), bus.req1_ready, vecs[i].r1);
            chk($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].wen);
            chk($sformatf("vec%0d_wr_addr", i), bus.wr_addr, vecs[i].wa);
            chk($sformatf("vec%0d_wr_data", i), bus.wr_data, vecs[i].wd);
            chk($sformatf("vec%0d_grant_id", i), bus.grant_id, vecs[i].gid);
            chk($sformatf("vec%0d_hazard", i), bus.rd_hazard, vecs[i].hz);
        end

        // Simultaneous accept into two empty buffers.
        fa = FIXED ? 5'd5 : 5'd4;  fd = FIXED ? 32'h22 : 32'h11;
        sa = FIXED ? 5'd4 : 5'd5;  sd = FIXED ? 32'h11 : 32'h22;
        drive(1, 4, 32'h11, 1, 5, 32'h22, 0);
        chk("dual_ready0", bus.req0_ready, 1);
        chk("dual_ready1", bus.req1_ready, 1);
        idle(0);
        chk("dual_wait_wr_en", bus.wr_en, 0);
        idle(0);
        chk("dual_first_wr_en", bus.wr_en, 1);
        chk("dual_first_addr", bus.wr_addr, fa);
        chk("dual_first_data", bus.wr_data, fd);
        chk("dual_first_gid", bus.grant_id, FIXED ? 1 : 0);
        idle(0);
        chk("dual_second_wr_en", bus.wr_en, 1);
        chk("dual_second_addr", bus.wr_addr, sa);
        chk("dual_second_data", bus.wr_data, sd);
        chk("dual_second_gid", bus.grant_id, FIXED ? 0 : 1);
        idle(0);
        chk("dual_done_wr_en", bus.wr_en, 0);

        // Sustained contention: both requesters valid for 8 cycles, then drain.
        acc_n[0] = 0; acc_n[1] = 0; wr_n[0] = 0; wr_n[1] = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 5'(10 + k), 32'(k), 1, 5'(20 + k), 32'(100 + k), 0);
            if (bus.req0_ready) acc_n[0]++;
            if (bus.req1_ready) acc_n[1]++;
            if (bus.wr_en) wr_n[bus.grant_id]++;
            if (k >= 2) begin
                chk($sformatf("stream%0d_wr_en", k), bus.wr_en, 1);
                chk($sformatf("stream%0d_gid", k), bus.grant_id, FIXED ? 1 : ((k - 2) % 2));
            end else begin
                chk($sformatf("stream%0d_wr_en", k), bus.wr_en, 0);
            end
        end
        for (int k = 0; k < 6; k++) begin
            idle(0);
            if (bus.wr_en) wr_n[bus.grant_id]++;
        end
        chk("stream_req0_all_written", wr_n[0], acc_n[0]);
        chk("stream_req1_all_written", wr_n[1], acc_n[1]);

        // Reset while both buffers are full and a write is on the port.
        drive(1, 9, 32'h99, 1, 12, 32'hCC, 12);
        drive(1, 9, 32'h99, 1, 12, 32'hCC, 12);
        idle(12);
        chk("midrst_pre_wr_en", bus.wr_en, 1);
        chk("midrst_pre_hazard", bus.rd_hazard, 1);
        #1 rst = 1;
        #1;
        chk("midrst_wr_en", bus.wr_en, 0);
        chk("midrst_ready0", bus.req0_ready, 0);
        chk("midrst_ready1", bus.req1_ready, 0);
        chk("midrst_hazard", bus.rd_hazard, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_reset();
        for (int k = 0; k < 4; k++) begin
            idle(12);
            chk($sformatf("postrst%0d_wr_en", k), bus.wr_en, 0);
            chk($sformatf("postrst%0d_hazard", k), bus.rd_hazard, 0);
        end

        for (int k = 0; k < 400; k++) rand_cycle(k);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the riscv32 data register file between two writeback requesters: req0 (ALU) and req1 (load unit).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a registered write port that drives the register file's data, location_write and write_enabled inputs.
- A read-hazard flag tells decode logic when a source register still has a write in flight.

Parameters:
WIDTH, 32, data width; matches the register file WIDTH.
AW, 5, register address width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
req0_valid  in  1  ALU writeback request.
req0_addr  in  AW  ALU destination register.
req0_data  in  WIDTH  ALU result.
req0_ready  out  1  ALU request accepted this cycle.
req1_valid  in  1  load writeback request.
req1_addr  in  AW  load destination register.
req1_data  in  WIDTH  load data.
req1_ready  out  1  load request accepted this cycle.
wr_en  out  1  to register file write_enabled.
wr_addr  out  AW  to register file location_write.
wr_data  out  WIDTH  to register file data.
grant_id  out  1  requester whose entry is on wr_* (valid when wr_en=1).
rd_addr  in  AW  source register being read by decode.
rd_hazard  out  1  rd_addr has a pending write.

Behaviour:
- Reset (async, takes effect immediately):
  - Holding buffers empty (full0=full1=0).
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0.
  - last_grant=1.
  - reqN_ready=0 and rd_hazard=0 while rst is high.
- Reset asserted mid-operation discards buffered and in-flight writes. No partial write may follow: wr_en drops asynchronously.
- Handshake: a transfer occurs on a posedge with reqN_valid && reqN_ready. Address and data are captured into bufferN.
- reqN_ready = !rst && (!fullN || grantN). A buffer being drained this cycle accepts new data in the same cycle, giving one write per cycle per requester.
- Grant logic:
  - Grant is computed only from full0, full1 and last_grant, never from valid. This guarantees no combinational loop.
  - Only one buffer full: that buffer is granted.
  - Both full: grant goes to the requester != last_grant. last_grant updates to the winner.
  - Neither full: no grant; wr_en=0 on the next cycle.
- Write port is registered. On a posedge with a grant, wr_en<=1, wr_addr/wr_data<=granted buffer, grant_id<=winner, and that buffer clears (unless it refills the same edge). With no grant, wr_en<=0 and wr_addr/wr_data hold their values.
- Latency:
  - Request accepted at edge E0 → wr_en high in the cycle after E1 → register file written at E2.
  - Minimum is 2 edges when uncontended. Contention adds 1 cycle per lost arbitration. The round robin bounds this to at most 1 loss.
- Register x0: a transfer with addr==0 completes the handshake but does not set fullN. No write to x0 is ever issued.
- Simultaneous accept on both ports with both buffers empty: both buffers fill. Arbitration on the next cycle follows last_grant.
- Same destination in both buffers: written in grant order; the later grant wins in the register file.
- rd_hazard = rd_addr!=0 && ((full0 && buf0_addr==rd_addr) || (full1 && buf1_addr==rd_addr) || (wr_en && wr_addr==rd_addr)). It is combinational.

Optional Feature:
Macro REGFILE_WB_FIXED_PRIO_EN.
- Defined: fixed priority. When both buffers are full, req1 (load) always wins. last_grant is not implemented. req0 may starve while req1 keeps its buffer full.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset release, req0 valid addr=3 data=0xDEADBEEF → accepted at E0; wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, grant_id=0 in the cycle after E1; wr_en=0 after that.
- Both valid on the same edge, addr0=4/0x11, addr1=5/0x22 → writes in order 4 (grant_id=0) then 5 (grant_id=1) on consecutive cycles. With REGFILE_WB_FIXED_PRIO_EN the order is 5 then 4.
- Both valid every cycle for 8 cycles → grant_id alternates 0,1,0,1…; wr_en high every cycle after the first two; no request dropped.
- req0 addr=0 data=0xFFFFFFFF → req0_ready=1, wr_en stays 0, rd_hazard=0 for rd_addr=0.
- req1 addr=7 accepted, rd_addr=7 → rd_hazard=1 from the accept edge until the cycle after wr_en for addr 7 deasserts; rd_addr=8 → 0 throughout.
- Assert rst while both buffers are full and wr_en=1 → wr_en, ready and rd_hazard drop immediately; after release, no write issues without a new request.
